psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//  Output FIFO that receives the per-column write stream from the SFP stage.
//  Holds one independent FIFO per column, so columns may arrive skewed in time.
//  Releases data only as whole aligned rows (all columns at once) to the readout/SRAM writer.
//  Sits between the SFP (accumulate/ReLU) stage and the core's output memory path.
// PARAMETERS
//  col      8    number of columns / per-column FIFOs
//  bw       16   data width per column (matches SFP psum_bw)
//  depth    64   entries per column FIFO; must be a power of two >= 2
//  aw       $clog2(depth)  derived address width; not overridden by users
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  in_data    in   col*bw  column k occupies [(k+1)*bw-1 : k*bw]
//  wr         in   col     per-column write request (driven by the SFP wr_ofifo)
//  rd         in   1       row read request from the downstream reader
//  out_data   out  col*bw  registered row output, same column packing as in_data
//  out_valid  out  1       one-cycle pulse: out_data updated this cycle
//  o_valid    out  1       every column FIFO is non-empty (a full row is available)
//  o_ready    out  1       no column FIFO is full
//  o_full     out  1       at least one column FIFO is full
//  o_empty    out  1       all column FIFOs are empty
//  o_ovf      out  1       sticky: a write hit a full column
//  o_udf      out  1       sticky: rd was asserted while o_valid was low
// BEHAVIOUR
//  Reset (async): all pointers = 0; out_data = 0; out_valid = 0; o_ovf = o_udf = 0.
//   After reset: o_empty = 1, o_ready = 1, o_valid = 0, o_full = 0.
//   Reset asserted mid-operation discards all stored contents.
//  Pointers per column: wptr[k] and rptr[k] are aw+1 bits.
//   empty_k = (wptr == rptr).
//   full_k = (MSBs differ) && (low aw bits equal).
//   Pointers wrap naturally at 2*depth; the address is ptr[aw-1:0].
//  Write, column k: accepted when wr[k] && !full_k, with full_k taken from the state before the edge.
//   On accept: mem_k[wptr] <= in_data slice; wptr[k]++.
//   A write to a full column is dropped, even if a read occurs the same cycle, and sets o_ovf.
//  Read: accepted when rd && o_valid, with o_valid taken from the state before the edge.
//   All columns pop together: rptr[k]++ for every k.
//   Next cycle: out_data = the popped row and out_valid = 1. Latency is 1 cycle from rd to data.
//   rd with o_valid = 0 is ignored, sets o_udf, and leaves out_data and pointers unchanged.
//   When no read is accepted, out_valid = 0 and out_data holds its last value.
//  Simultaneous write and read on a non-full, non-empty column: both occur; occupancy is unchanged.
//   A write into an empty column is not readable in the same cycle: there is no bypass.
//   The new entry becomes visible to o_valid on the next cycle.
//  Status outputs (o_valid, o_ready, o_full, o_empty) are combinational from the pointers only.
//   They have no combinational path from wr or rd.
//  Data is stored verbatim. No sign or width manipulation is applied: the FIFO is bw-bit transparent.
//  Skew: a column may lead the others by up to depth entries; o_valid waits for the slowest column.
//  o_ovf and o_udf clear only on reset.
// STRUCTURE
//  Shared package / header: no new typedefs are needed.
//   Column-slice helper macro (k*bw offsets) lives with the other core constants.
//  Sub-module fifo_col: one column FIFO (bw x depth storage, wptr/rptr, full/empty, push/pop).
//   Instantiated col times in a generate loop.
//  Top level holds:
//   the AND/OR reduction of the per-column flags;
//   the row-pop qualify logic;
//   the out_data / out_valid registers;
//   the sticky error flags.
// TESTING
//  1. Reset, then write wr=8'hFF for three cycles with column k = 16'h0100+k, +1, +2; rd for three cycles
//     -> out_valid pulses three times, each 1 cycle after rd; rows arrive in order; o_empty=1 at the end.
//  2. Skewed arrival: wr[0] at cycle 0 and wr[7:1] at cycle 5 (the same row)
//     -> o_valid stays 0 until the cycle after column 7 is written, then goes to 1; row read back intact.
//  3. Fill column 3 with 64 writes, then a 65th write of 16'hDEAD
//     -> o_full=1, o_ready=0, o_ovf=1; the DEAD value never appears on out_data.
//  4. rd while empty -> o_udf=1, out_valid=0, out_data unchanged, pointers unchanged.
//  5. Steady state at occupancy 1, with wr=8'hFF and rd every cycle for 200 cycles (pointer wrap)
//     -> data in order with no loss; o_valid stays 1; o_ovf=0 and o_udf=0.
//  6. Assert reset with 10 rows stored and rd active
//     -> all outputs return to their reset values immediately; no out_valid after reset.
//     A subsequent single-row write/read returns that new row only.

Source files
------------

// File: rtl/psum_ofifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_ofifo_pkg
//  Description : Core constants shared by the output FIFO slice and a helper
//                that locates a column slice inside a packed row.
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_ofifo_pkg;

    localparam int COL_DEF   = 8;   // number of columns
    localparam int BW_DEF    = 16;  // bits per column (SFP psum width)
    localparam int DEPTH_DEF = 64;  // entries per column FIFO (power of two)

    // LSB position of column k inside a packed COL*BW row.
    function automatic int col_lsb(input int k, input int bw);
        return k * bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_ofifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : psum_ofifo_if
//  Description : Row/column bus between the SFP stage, the output FIFO and
//                the downstream row reader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psum_ofifo_if
    import psum_ofifo_pkg::*;
#(
    parameter int COL = COL_DEF,
    parameter int BW  = BW_DEF
);
    logic [COL*BW-1:0] in_data;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [COL*BW-1:0] out_data;
    logic              out_valid;
    logic              o_valid;
    logic              o_ready;
    logic              o_full;
    logic              o_empty;
    logic              o_ovf;
    logic              o_udf;

    // Producer/consumer side (SFP writer plus row reader).
    modport master (
        output in_data, wr, rd,
        input  out_data, out_valid, o_valid, o_ready, o_full, o_empty, o_ovf, o_udf
    );

    // FIFO side.
    modport slave (
        input  in_data, wr, rd,
        output out_data, out_valid, o_valid, o_ready, o_full, o_empty, o_ovf, o_udf
    );
endinterface
`default_nettype wire

// File: rtl/psum_ofifo_fifo_col.sv
`default_nettype none
// ============================================================================
//  Module      : psum_ofifo_fifo_col
//  Description : Single-column FIFO. Pointers carry one extra wrap bit so
//                full and empty are distinguishable without a counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_ofifo_fifo_col #(
    parameter int BW    = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          push_i,
    input  wire logic          pop_i,
    input  wire logic [BW-1:0] wdata_i,
    output logic      [BW-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          w_push;
    logic          w_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A push into a full column is dropped; pop is guarded so the pointers
    // can never cross even if the caller misbehaves.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Head of the queue is presented combinationally; the top registers it.
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer advance for accepted push/pop.
    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, w_push};
        rptr_d = rptr_q + {{AW{1'b0}}, w_pop};
    end

    // Pointer registers, cleared asynchronously to drop all stored entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_ofifo.sv
`default_nettype none
// ============================================================================
//  Module      : psum_ofifo
//  Description : Per-column output FIFO. Columns fill independently (skewed
//                SFP writes) and are released only as whole aligned rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int COL   = COL_DEF,
    parameter int BW    = BW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  wire logic     clk,
    input  wire logic     reset,
    psum_ofifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    logic [COL-1:0]    w_full;
    logic [COL-1:0]    w_empty;
    logic [COL*BW-1:0] w_head;
    logic              w_row_avail;
    logic              w_pop;

    logic [COL*BW-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    for (genvar k = 0; k < COL; k++) begin : g_col
        localparam int LSB = col_lsb(k, BW);

        psum_ofifo_fifo_col #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (bus.wr[k]),
            .pop_i   (w_pop),
            .wdata_i (bus.in_data[LSB +: BW]),
            .rdata_o (w_head[LSB +: BW]),
            .full_o  (w_full[k]),
            .empty_o (w_empty[k])
        );
    end

    // A row exists only once the slowest column holds an entry.
    assign w_row_avail = ~|w_empty;
    assign w_pop       = bus.rd && w_row_avail;

    assign bus.o_valid   = w_row_avail;
    assign bus.o_ready   = ~|w_full;
    assign bus.o_full    = |w_full;
    assign bus.o_empty   = &w_empty;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.o_ovf     = ovf_q;
    assign bus.o_udf     = udf_q;

    // Next-state for the row output and the sticky error flags.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = w_pop;
        ovf_d       = ovf_q | (|(bus.wr & w_full));
        udf_d       = udf_q | (bus.rd & ~w_row_avail);
        if (w_pop) begin
            out_data_d = w_head;
        end
    end

    // Output row register and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_ofifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_ofifo
//  Description : Self-checking bench for psum_ofifo: directed vector table,
//                hand-written corner sequences and randomized traffic, all
//                checked against a queue-per-column reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int RW    = COL * BW;

    logic clk;
    logic reset;

    psum_ofifo_if #(.COL(COL), .BW(BW)) bus ();

    psum_ofifo #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per column plus the registered outputs.
    logic [BW-1:0] mq [COL][$];
    logic [RW-1:0] exp_out;
    logic          exp_ov;
    logic          exp_ovf;
    logic          exp_udf;

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        n_checks++;
        if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < COL; k++) mq[k].delete();
        exp_out = '0;
        exp_ov  = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    function automatic bit m_avail();
        for (int k = 0; k < COL; k++) if (mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the specified behaviour, using pre-edge state.
    task automatic model_step(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
        bit avail;
        bit full_pre [COL];
        avail = m_avail();
        for (int k = 0; k < COL; k++) full_pre[k] = (mq[k].size() == DEPTH);
        exp_ov = r && avail;
        if (r && avail) begin
            for (int k = 0; k < COL; k++) exp_out[k*BW +: BW] = mq[k].pop_front();
        end
        if (r && !avail) exp_udf = 1'b1;
        for (int k = 0; k < COL; k++) begin
            if (w[k]) begin
                if (full_pre[k]) exp_ovf = 1'b1;
                else mq[k].push_back(d[k*BW +: BW]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit any_full, all_empty;
        any_full  = 1'b0;
        all_empty = 1'b1;
        for (int k = 0; k < COL; k++) begin
            if (mq[k].size() == DEPTH) any_full = 1'b1;
            if (mq[k].size() != 0) all_empty = 1'b0;
        end
        chk({tag, ".out_data"},  bus.out_data,        exp_out);
        chk({tag, ".out_valid"}, RW'(bus.out_valid),  RW'(exp_ov));
        chk({tag, ".o_valid"},   RW'(bus.o_valid),    RW'(m_avail()));
        chk({tag, ".o_ready"},   RW'(bus.o_ready),    RW'(!any_full));
        chk({tag, ".o_full"},    RW'(bus.o_full),     RW'(any_full));
        chk({tag, ".o_empty"},   RW'(bus.o_empty),    RW'(all_empty));
        chk({tag, ".o_ovf"},     RW'(bus.o_ovf),      RW'(exp_ovf));
        chk({tag, ".o_udf"},     RW'(bus.o_udf),      RW'(exp_udf));
    endtask

    // Apply inputs for one cycle, then check just after the edge.
    task automatic cyc(input string tag, input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
        bus.wr      = w;
        bus.in_data = d;
        bus.rd      = r;
        @(posedge clk);
        #1;
        model_step(w, d, r);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        bus.wr      = '0;
        bus.rd      = 1'b0;
        bus.in_data = '0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [RW-1:0] mk_row(input logic [BW-1:0] base);
        logic [RW-1:0] r;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = base + BW'(k);
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    typedef struct {
        logic [COL-1:0] wr;
        logic [BW-1:0]  base;
        logic           rd;
        logic           e_ov;
        logic           e_valid;
        logic           e_empty;
        logic           e_has;
        logic [BW-1:0]  e_base;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [RW-1:0] row;
        logic [RW-1:0] d;
        n_checks = 0;
        n_pass   = 0;

        tbl[0] = '{8'hFF, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{8'hFF, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{8'hFF, 16'h0102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100};
        tbl[4] = '{8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0101};
        tbl[5] = '{8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0102};
        tbl[6] = '{8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0102};

        reset       = 1'b1;
        bus.wr      = '0;
        bus.rd      = 1'b0;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b0;

        // Three aligned rows in, three rows out.
        for (int i = 0; i < 7; i++) begin
            cyc("t1", tbl[i].wr, mk_row(tbl[i].base), tbl[i].rd);
            chk("t1.tbl_out_valid", RW'(bus.out_valid), RW'(tbl[i].e_ov));
            chk("t1.tbl_o_valid",   RW'(bus.o_valid),   RW'(tbl[i].e_valid));
            chk("t1.tbl_o_empty",   RW'(bus.o_empty),   RW'(tbl[i].e_empty));
            chk("t1.tbl_out_data",  bus.out_data, tbl[i].e_has ? mk_row(tbl[i].e_base) : '0);
        end

        // Skewed arrival: column 0 leads by five cycles.
        do_reset("t2.reset");
        row = mk_row(16'h2000);
        cyc("t2.c0", 8'h01, row, 1'b0);
        chk("t2.valid_lead", RW'(bus.o_valid), RW'(1'b0));
        for (int i = 0; i < 4; i++) begin
            cyc("t2.idle", 8'h00, '0, 1'b0);
            chk("t2.valid_wait", RW'(bus.o_valid), RW'(1'b0));
        end
        cyc("t2.rest", 8'hFE, row, 1'b0);
        chk("t2.valid_up", RW'(bus.o_valid), RW'(1'b1));
        cyc("t2.rd", 8'h00, '0, 1'b1);
        chk("t2.row", bus.out_data, row);

        // Fill column 3, overflow with DEAD, then drain without DEAD showing.
        do_reset("t3.reset");
        for (int i = 0; i < DEPTH; i++) begin
            d = '0;
            d[3*BW +: BW] = BW'(16'h3000 + i);
            cyc("t3.fill", 8'h08, d, 1'b0);
        end
        chk("t3.full",  RW'(bus.o_full),  RW'(1'b1));
        chk("t3.ready", RW'(bus.o_ready), RW'(1'b0));
        chk("t3.ovf0",  RW'(bus.o_ovf),   RW'(1'b0));
        d = '0;
        d[3*BW +: BW] = 16'hDEAD;
        cyc("t3.over", 8'h08, d, 1'b0);
        chk("t3.ovf1", RW'(bus.o_ovf), RW'(1'b1));
        for (int i = 0; i < DEPTH; i++) cyc("t3.others", 8'hF7, rand_row(), 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc("t3.drain", 8'h00, '0, 1'b1);
            n_checks++;
            if (bus.out_data[3*BW +: BW] === 16'hDEAD)
                $display("FAIL t3.no_dead: got %h expected not dead", bus.out_data[3*BW +: BW]);
            else n_pass++;
        end

        // Read while empty: ignored, sticky underflow.
        cyc("t4.udf", 8'h00, '0, 1'b1);
        chk("t4.udf_flag",  RW'(bus.o_udf),     RW'(1'b1));
        chk("t4.no_valid",  RW'(bus.out_valid), RW'(1'b0));
        row = mk_row(16'h4400);
        cyc("t4.wr", 8'hFF, row, 1'b0);
        cyc("t4.rd", 8'h00, '0, 1'b1);
        chk("t4.row", bus.out_data, row);

        // Steady state at occupancy one across pointer wrap.
        do_reset("t5.reset");
        cyc("t5.prime", 8'hFF, rand_row(), 1'b0);
        for (int i = 0; i < 200; i++) begin
            cyc("t5.stream", 8'hFF, rand_row(), 1'b1);
            chk("t5.valid", RW'(bus.o_valid), RW'(1'b1));
        end
        chk("t5.ovf", RW'(bus.o_ovf), RW'(1'b0));
        chk("t5.udf", RW'(bus.o_udf), RW'(1'b0));

        // Randomized skewed traffic.
        do_reset("rnd.reset");
        for (int i = 0; i < 600; i++) begin
            logic [COL-1:0] w;
            logic           r;
            if (i < 300) w = COL'($urandom) | COL'($urandom);
            else         w = COL'($urandom) & COL'($urandom);
            r = ($urandom_range(0, 2) == 0);
            cyc("rnd", w, rand_row(), r);
        end

        // Async reset with rows stored and a read pending.
        do_reset("t6.reset");
        for (int i = 0; i < 10; i++) cyc("t6.fill", 8'hFF, rand_row(), 1'b0);
        bus.wr = '0;
        bus.rd = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk);
        #1;
        check_all("t6.held");
        chk("t6.no_valid", RW'(bus.out_valid), RW'(1'b0));
        bus.rd = 1'b0;
        reset  = 1'b0;
        row = mk_row(16'h6600);
        cyc("t6.wr", 8'hFF, row, 1'b0);
        cyc("t6.rd", 8'h00, '0, 1'b1);
        chk("t6.row",   bus.out_data, row);
        chk("t6.empty", RW'(bus.o_empty), RW'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
